// File: rtl/gige_pkg.sv
// Shared GMII/Ethernet constants, receive FSM state type and small helpers.
package gige_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_SEED      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the Ethernet CRC32, LSB-first (reflected) form.
module crc32_d8
    import gige_pkg::*;
(
    input  logic [7:0]  data_i,
    input  logic [31:0] crc_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_REF = bitrev32(CRC_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ POLY_REF;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_checker.sv
// GMII receive frame checker: preamble/SFD tracking, FCS and length validation,
// per-frame good/bad pulses and saturating event counters.
module gmii_rx_checker
    import gige_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1522
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rxd,
    input  logic        rx_er,
    input  logic        stat_clear,
    output logic        frame_good,
    output logic        frame_bad,
    output logic [15:0] frame_len,
    output logic [15:0] good_count,
    output logic [15:0] crc_err_count,
    output logic [15:0] len_err_count,
    output logic [15:0] rx_err_count,
    output logic [15:0] sfd_err_count,
    output logic        busy
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
    // The register runs reflected, so the residue is compared in reflected form.
    localparam logic [31:0] RESIDUE_REF = bitrev32(CRC_RESIDUE);

    rx_state_e   state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_nxt;
    logic [15:0] bytes_q, bytes_d;
    logic        rxerr_q, rxerr_d;
    logic        good_q, bad_q;
    logic [15:0] len_q;
    logic [15:0] good_cnt_q, crc_cnt_q, len_cnt_q, rxer_cnt_q, sfd_cnt_q;
    logic        ev_good, ev_crc, ev_len, ev_rxer, ev_sfd, frame_end;

    crc32_d8 u_crc (
        .data_i (rxd),
        .crc_i  (crc_q),
        .crc_o  (crc_nxt)
    );

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    if (rxd == PREAMBLE_BYTE)  state_d = ST_PREAMBLE;
                    else if (rxd == SFD_BYTE)  state_d = ST_DATA;
                    else                       state_d = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv)                    state_d = ST_IDLE;
                else if (rxd == SFD_BYTE)      state_d = ST_DATA;
                else if (rxd != PREAMBLE_BYTE) state_d = ST_DROP;
            end
            ST_DATA: if (!rx_dv) state_d = ST_IDLE;
            ST_DROP: if (!rx_dv) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-cycle events and datapath next-state; the CRC reseeds whenever not accumulating.
    always_comb begin
        ev_good   = 1'b0;
        ev_crc    = 1'b0;
        ev_len    = 1'b0;
        ev_rxer   = 1'b0;
        ev_sfd    = 1'b0;
        frame_end = 1'b0;
        crc_d     = CRC_SEED;
        bytes_d   = '0;
        rxerr_d   = 1'b0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                ev_sfd = rx_dv && (rxd != PREAMBLE_BYTE) && (rxd != SFD_BYTE);
            end
            ST_PREAMBLE: begin
                ev_sfd = !rx_dv || ((rxd != PREAMBLE_BYTE) && (rxd != SFD_BYTE));
            end
            ST_DATA: begin
                if (rx_dv) begin
                    crc_d   = crc_nxt;
                    bytes_d = sat_inc16(bytes_q);
                    rxerr_d = rxerr_q | rx_er;
                end else begin
                    frame_end = 1'b1;
                    if (rxerr_q)                                   ev_rxer = 1'b1;
                    else if (bytes_q < MIN_LEN || bytes_q > MAX_LEN) ev_len = 1'b1;
                    else if (crc_q != RESIDUE_REF)                 ev_crc  = 1'b1;
                    else                                           ev_good = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            crc_q   <= CRC_SEED;
            bytes_q <= '0;
            rxerr_q <= 1'b0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            crc_q   <= crc_d;
            bytes_q <= bytes_d;
            rxerr_q <= rxerr_d;
            good_q  <= ev_good;
            bad_q   <= frame_end & ~ev_good;
            if (frame_end) len_q <= bytes_q;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (reset || stat_clear) begin
            good_cnt_q <= '0;
            crc_cnt_q  <= '0;
            len_cnt_q  <= '0;
            rxer_cnt_q <= '0;
            sfd_cnt_q  <= '0;
        end else begin
            if (ev_good) good_cnt_q <= sat_inc16(good_cnt_q);
            if (ev_crc)  crc_cnt_q  <= sat_inc16(crc_cnt_q);
            if (ev_len)  len_cnt_q  <= sat_inc16(len_cnt_q);
            if (ev_rxer) rxer_cnt_q <= sat_inc16(rxer_cnt_q);
            if (ev_sfd)  sfd_cnt_q  <= sat_inc16(sfd_cnt_q);
        end
    end

    assign frame_good    = good_q;
    assign frame_bad     = bad_q;
    assign frame_len     = len_q;
    assign good_count    = good_cnt_q;
    assign crc_err_count = crc_cnt_q;
    assign len_err_count = len_cnt_q;
    assign rx_err_count  = rxer_cnt_q;
    assign sfd_err_count = sfd_cnt_q;

endmodule
